// File: rtl/psm_deadtime_pkg.sv
// Shared types and constants for the multi-channel dead-time generator.
// Output pair layout: bit HI_IDX drives the high-side switch, bit LO_IDX the low side.
package psm_deadtime_pkg;

  localparam int DEF_BITS_DATA = 8;
  localparam int HI_IDX        = 0;
  localparam int LO_IDX        = 1;

  typedef enum logic [2:0] {
    OFF,
    HI_ON,
    LO_ON,
    DT_HI,
    DT_LO
  } chState_e;

endpackage

// File: rtl/psm_deadtime_mc_if.sv
// Control/status bundle between the modulators and the dead-time generator.
// The master drives configuration and PSM bits; the slave returns the gate pairs and status.
interface psm_deadtime_mc_if #(
  parameter int CHANNELS  = 3,
  parameter int BITS_DATA = psm_deadtime_pkg::DEF_BITS_DATA
);

  logic [BITS_DATA-1:0]  iDT_RISE;
  logic [BITS_DATA-1:0]  iDT_FALL;
  logic                  iEN;
  logic                  iFAULT;
  logic                  iFAULT_CLR;
  logic [CHANNELS-1:0]   iPSM;
  logic [2*CHANNELS-1:0] oPSM;
  logic [CHANNELS-1:0]   oDT_ACTIVE;
  logic                  oFAULT;

  modport master (
    output iDT_RISE, iDT_FALL, iEN, iFAULT, iFAULT_CLR, iPSM,
    input  oPSM, oDT_ACTIVE, oFAULT
  );

  modport slave (
    input  iDT_RISE, iDT_FALL, iEN, iFAULT, iFAULT_CLR, iPSM,
    output oPSM, oDT_ACTIVE, oFAULT
  );

endinterface

// File: rtl/psm_deadtime_ch.sv
// One complementary channel: a turn-on is only reached after an uninterrupted dead-time interval.
// Outputs are registered from a decode of the next state, so they change together with the state.
module psm_deadtime_ch
  import psm_deadtime_pkg::*;
#(
  parameter int BITS_DATA = DEF_BITS_DATA
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_run,
  input  logic                 i_psm,
  input  logic [BITS_DATA-1:0] i_dtRise,
  input  logic [BITS_DATA-1:0] i_dtFall,
  output logic [1:0]           o_psm,
  output logic                 o_dtActive
);

  chState_e             r_state;
  chState_e             w_nextState;
  logic [BITS_DATA-1:0] r_cnt;
  logic [BITS_DATA-1:0] w_cntNext;
  logic [BITS_DATA-1:0] w_riseEff;
  logic [BITS_DATA-1:0] w_fallEff;
  logic [1:0]           r_psm;
  logic [1:0]           w_psmNext;
  logic                 r_dtActive;
  logic                 w_dtActiveNext;

  // A zero dead time still guarantees one both-off cycle.
  assign w_riseEff = (i_dtRise == '0) ? BITS_DATA'(1) : i_dtRise;
  assign w_fallEff = (i_dtFall == '0) ? BITS_DATA'(1) : i_dtFall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= OFF;
      r_cnt      <= '0;
      r_psm      <= 2'b00;
      r_dtActive <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_cntNext;
      r_psm      <= w_psmNext;
      r_dtActive <= w_dtActiveNext;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_cntNext   = r_cnt;
    if (!i_run) begin
      w_nextState = OFF;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_nextState = i_psm ? DT_HI : DT_LO;
          w_cntNext   = i_psm ? w_riseEff : w_fallEff;
        end
        HI_ON: begin
          if (!i_psm) begin
            w_nextState = DT_LO;
            w_cntNext   = w_fallEff;
          end
        end
        LO_ON: begin
          if (i_psm) begin
            w_nextState = DT_HI;
            w_cntNext   = w_riseEff;
          end
        end
        // A reversal restarts the opposite interval from its full length.
        DT_HI: begin
          if (!i_psm) begin
            w_nextState = DT_LO;
            w_cntNext   = w_fallEff;
          end else if (r_cnt <= BITS_DATA'(1)) begin
            w_nextState = HI_ON;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt - BITS_DATA'(1);
          end
        end
        DT_LO: begin
          if (i_psm) begin
            w_nextState = DT_HI;
            w_cntNext   = w_riseEff;
          end else if (r_cnt <= BITS_DATA'(1)) begin
            w_nextState = LO_ON;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt - BITS_DATA'(1);
          end
        end
        default: begin
          w_nextState = OFF;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_psmNext      = 2'b00;
    w_dtActiveNext = 1'b0;
    case (w_nextState)
      HI_ON:        w_psmNext[HI_IDX] = 1'b1;
      LO_ON:        w_psmNext[LO_IDX] = 1'b1;
      DT_HI, DT_LO: w_dtActiveNext    = 1'b1;
      default:      w_psmNext         = 2'b00;
    endcase
  end

  assign o_psm      = r_psm;
  assign o_dtActive = r_dtActive;

endmodule

// File: rtl/psm_deadtime_mc.sv
// N-channel dead-time generator: fault latch, registered enable/run decode and the channel array.
// Disabling or tripping takes effect one edge after the request is sampled.
module psm_deadtime_mc
  import psm_deadtime_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int BITS_DATA = DEF_BITS_DATA
) (
  input logic               CLK,
  input logic               RST,
  psm_deadtime_mc_if.slave  bus
);

  logic                  r_fault;
  logic                  r_en;
  logic                  w_run;
  logic [2*CHANNELS-1:0] w_psm;
  logic [CHANNELS-1:0]   w_dtActive;

  // Set has priority over clear, so a held fault cannot be cleared away.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fault <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_en <= bus.iEN;
      if (bus.iFAULT) begin
        r_fault <= 1'b1;
      end else if (bus.iFAULT_CLR) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign w_run = r_en & ~r_fault;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    psm_deadtime_ch #(
      .BITS_DATA(BITS_DATA)
    ) u_ch (
      .CLK       (CLK),
      .RST       (RST),
      .i_run     (w_run),
      .i_psm     (bus.iPSM[n]),
      .i_dtRise  (bus.iDT_RISE),
      .i_dtFall  (bus.iDT_FALL),
      .o_psm     (w_psm[2*n +: 2]),
      .o_dtActive(w_dtActive[n])
    );
  end

  assign bus.oPSM       = w_psm;
  assign bus.oDT_ACTIVE = w_dtActive;
  assign bus.oFAULT     = r_fault;

endmodule
